// File: rtl/and16_pkg.sv
// and16_checker shared types and constants.
// FSM state encoding and default widths.
package and16_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } chk_state_t;

  localparam int ERR_W_DEFAULT = 32;
  localparam int SETTLE_W      = 4;

endpackage

// File: rtl/and16_if.sv
// Bus between the and16 checker and the unit under test.
// master = checker side, slave = DUT/host side.
interface and16_if #(
  parameter int WIDTH = 16,
  parameter int ERR_W = 32
);

  logic             START;
  logic [WIDTH-1:0] DUT_OUT;
  logic [WIDTH-1:0] DUT_A;
  logic [WIDTH-1:0] DUT_B;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [ERR_W-1:0] ERR_CNT;
  logic [WIDTH-1:0] FAIL_A;
  logic [WIDTH-1:0] FAIL_B;
  logic [WIDTH-1:0] FAIL_OUT;

  modport master (
    input  START, DUT_OUT,
    output DUT_A, DUT_B, BUSY, DONE, PASS,
    output ERR_CNT, FAIL_A, FAIL_B, FAIL_OUT
  );

  modport slave (
    output START, DUT_OUT,
    input  DUT_A, DUT_B, BUSY, DONE, PASS,
    input  ERR_CNT, FAIL_A, FAIL_B, FAIL_OUT
  );

endinterface

// File: rtl/and16_checker_operand_sweep.sv
// A/B operand counter pair: B inner loop, A outer loop.
// last flags the all-ones pair; the pair holds there.
module operand_sweep #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             last
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  assign last = (a_q == ONES) && (b_q == ONES);

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (clear) begin
      a_d = '0;
      b_d = '0;
    end else if (advance && !last) begin
      b_d = b_q + 1'b1;
      if (b_q == ONES) a_d = a_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A = a_q;
  assign B = b_q;

endmodule

// File: rtl/and16_checker.sv
// Exhaustive AND-unit sweep checker: drives A/B, compares OUT,
// counts mismatches and latches the first failing vector.
module and16_checker
  import and16_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 0,
  parameter int ERR_W  = ERR_W_DEFAULT
) (
  input logic     CLK,
  input logic     RST_N,
  and16_if.master bus
);

  localparam bit HAS_WAIT = (SETTLE > 0);
  localparam logic [SETTLE_W-1:0] CNT_END =
    SETTLE_W'(HAS_WAIT ? SETTLE - 1 : 0);

  chk_state_t          state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [WIDTH-1:0]    fa_q, fa_d;
  logic [WIDTH-1:0]    fb_q, fb_d;
  logic [WIDTH-1:0]    fo_q, fo_d;
  logic [WIDTH-1:0]    op_a, op_b;
  logic                last, start_ok, mis;
  logic                clear, advance, busy, done;

  operand_sweep #(.WIDTH(WIDTH)) u_sweep (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clear   (clear),
    .advance (advance),
    .A       (op_a),
    .B       (op_b),
    .last    (last)
  );

  assign start_ok = bus.START &&
    (state_q == IDLE || state_q == DONE);
  assign mis = (state_q == CHECK) &&
    (bus.DUT_OUT != (op_a & op_b));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          if (HAS_WAIT) state_d = WAIT;
          else          state_d = CHECK;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_END) state_d = CHECK;
      end
      CHECK: begin
        if (last)          state_d = DONE;
        else if (HAS_WAIT) state_d = WAIT;
        else               state_d = CHECK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clear   = start_ok;
    advance = (state_q == CHECK);
    busy    = (state_q == WAIT) || (state_q == CHECK);
    done    = (state_q == DONE);
  end

  // Only the first mismatch of a sweep is latched.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT) cnt_d = cnt_q + 1'b1;
    err_d = err_q;
    fa_d  = fa_q;
    fb_d  = fb_q;
    fo_d  = fo_q;
    if (clear) begin
      err_d = '0;
      fa_d  = '0;
      fb_d  = '0;
      fo_d  = '0;
    end else if (mis) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) begin
        fa_d = op_a;
        fb_d = op_b;
        fo_d = bus.DUT_OUT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      err_q <= '0;
      fa_q  <= '0;
      fb_q  <= '0;
      fo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      fa_q  <= fa_d;
      fb_q  <= fb_d;
      fo_q  <= fo_d;
    end
  end

  assign bus.DUT_A    = op_a;
  assign bus.DUT_B    = op_b;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.PASS     = done && (err_q == '0);
  assign bus.ERR_CNT  = err_q;
  assign bus.FAIL_A   = fa_q;
  assign bus.FAIL_B   = fb_q;
  assign bus.FAIL_OUT = fo_q;

endmodule

// File: tb/tb_and16_checker.sv
// Bench for and16_checker: four WIDTH=4 instances against
// a per-vector sweep model plus hand-computed pins.
module tb_and16_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cmp = 0;
  int bad = 0;
  int k = 0;
  bit trk = 1'b0;
  bit hold = 1'b0;
  int mode0 = 0;
  int pref[257];

  logic [3:0] st;
  logic       dn[4], bs[4], ps[4];
  logic [31:0] ec[4];
  logic [3:0] aa[4], bb[4], fa[4], fb[4], fo[4];

  and16_if #(.WIDTH(4), .ERR_W(32)) b0();
  and16_if #(.WIDTH(4), .ERR_W(32)) b1();
  and16_if #(.WIDTH(4), .ERR_W(32)) b2();
  and16_if #(.WIDTH(4), .ERR_W(4))  b3();

  and16_checker #(.WIDTH(4), .SETTLE(0), .ERR_W(32)) u0 (
    .CLK(clk), .RST_N(rst_n), .bus(b0));
  and16_checker #(.WIDTH(4), .SETTLE(2), .ERR_W(32)) u1 (
    .CLK(clk), .RST_N(rst_n), .bus(b1));
  and16_checker #(.WIDTH(4), .SETTLE(1), .ERR_W(32)) u2 (
    .CLK(clk), .RST_N(rst_n), .bus(b2));
  and16_checker #(.WIDTH(4), .SETTLE(0), .ERR_W(4)) u3 (
    .CLK(clk), .RST_N(rst_n), .bus(b3));

  assign b0.START = st[0];
  assign b1.START = st[1];
  assign b2.START = st[2];
  assign b3.START = st[3];

  // DUT models: fault-selectable, two-stage pipelined, inverted
  logic [3:0] p1a, p2a, p1b, p2b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1a <= '0; p2a <= '0; p1b <= '0; p2b <= '0;
    end else begin
      p1a <= b1.DUT_A & b1.DUT_B;
      p2a <= p1a;
      p1b <= b2.DUT_A & b2.DUT_B;
      p2b <= p1b;
    end
  end

  assign b0.DUT_OUT = (mode0 == 1) ? (b0.DUT_A & b0.DUT_B & 4'hE) :
                      (mode0 == 2) ? ~(b0.DUT_A & b0.DUT_B) :
                      (b0.DUT_A & b0.DUT_B);
  assign b1.DUT_OUT = p2a;
  assign b2.DUT_OUT = p2b;
  assign b3.DUT_OUT = ~(b3.DUT_A & b3.DUT_B);

  assign {dn[0], bs[0], ps[0]} = {b0.DONE, b0.BUSY, b0.PASS};
  assign {dn[1], bs[1], ps[1]} = {b1.DONE, b1.BUSY, b1.PASS};
  assign {dn[2], bs[2], ps[2]} = {b2.DONE, b2.BUSY, b2.PASS};
  assign {dn[3], bs[3], ps[3]} = {b3.DONE, b3.BUSY, b3.PASS};
  assign ec[0] = b0.ERR_CNT;
  assign ec[1] = b1.ERR_CNT;
  assign ec[2] = b2.ERR_CNT;
  assign ec[3] = {28'd0, b3.ERR_CNT};
  assign {aa[0], bb[0], fa[0], fb[0], fo[0]} =
    {b0.DUT_A, b0.DUT_B, b0.FAIL_A, b0.FAIL_B, b0.FAIL_OUT};
  assign {aa[1], bb[1], fa[1], fb[1], fo[1]} =
    {b1.DUT_A, b1.DUT_B, b1.FAIL_A, b1.FAIL_B, b1.FAIL_OUT};
  assign {aa[2], bb[2], fa[2], fb[2], fo[2]} =
    {b2.DUT_A, b2.DUT_B, b2.FAIL_A, b2.FAIL_B, b2.FAIL_OUT};
  assign {aa[3], bb[3], fa[3], fb[3], fo[3]} =
    {b3.DUT_A, b3.DUT_B, b3.FAIL_A, b3.FAIL_B, b3.FAIL_OUT};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual %0h required %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Vector v is sampled at edge (v+1)(s+1); a DUT of latency lat
  // returns the AND of whatever pair was on the bus lat edges earlier.
  function automatic void model(input int s, input int lat,
      input int flt, input int errw, input bit keep,
      output int cnt, output logic [3:0] a1,
      output logic [3:0] b1o, output logic [3:0] o1);
    logic [3:0] a, b, o;
    int t, sv;
    longint mx;
    mx = (longint'(1) << errw) - 1;
    cnt = 0; a1 = '0; b1o = '0; o1 = '0;
    if (keep) pref[0] = 0;
    for (int v = 0; v < 256; v++) begin
      a = 4'(v >> 4);
      b = 4'(v);
      t = (v + 1) * (s + 1) - lat;
      sv = (t <= 0) ? 0 : (t - 1) / (s + 1);
      o = 4'(sv >> 4) & 4'(sv);
      if (flt == 1) o = o & 4'hE;
      else if (flt == 2) o = ~o;
      if (o != (a & b)) begin
        if (cnt == 0) begin a1 = a; b1o = b; o1 = o; end
        if (cnt < mx) cnt++;
      end
      if (keep) pref[v + 1] = cnt;
    end
  endfunction

  // Per-cycle compare of instance 0 against the model, k = edges since START
  always @(negedge clk) begin
    if (trk) begin
      if (k >= 0) begin : cyc
        logic [7:0] v;
        logic xb, xd;
        logic [31:0] xe;
        if (k < 256) begin
          v = 8'(k); xb = 1'b1; xd = 1'b0; xe = pref[k];
        end else if (k == 256 || !hold) begin
          v = 8'hFF; xb = 1'b0; xd = 1'b1; xe = pref[256];
        end else begin
          v = 8'h00; xb = 1'b1; xd = 1'b0; xe = 0;
        end
        chk("cyc_A", aa[0], v[7:4]);
        chk("cyc_B", bb[0], v[3:0]);
        chk("cyc_busy", bs[0], xb);
        chk("cyc_done", dn[0], xd);
        chk("cyc_err", ec[0], xe);
        chk("cyc_pass", ps[0], xd && xe == 0);
      end
      if (k >= 257) trk = 1'b0;
      k++;
    end
  end

  task automatic run0(input bit hd, input int flt);
    int n, cnt;
    logic [3:0] a1, b1v, o1;
    mode0 = flt;
    model(0, 0, flt, 32, 1'b1, cnt, a1, b1v, o1);
    hold = hd;
    @(posedge clk); #1 st[0] = 1'b1; k = -1; trk = 1'b1;
    @(posedge clk); #1 if (!hd) st[0] = 1'b0;
    n = 0;
    while (n < 3000 && !dn[0]) begin
      @(posedge clk); #1 n++;
    end
    chk("run0_done_edge", n, 256);
    chk("run0_err", ec[0], cnt);
    chk("run0_pass", ps[0], cnt == 0);
    chk("run0_fail_a", fa[0], a1);
    chk("run0_fail_b", fb[0], b1v);
    chk("run0_fail_out", fo[0], o1);
    @(posedge clk); #1 st[0] = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic run_ext(input int i, input int s, input int lat,
                         input int flt, input int errw);
    int n, cnt;
    logic [3:0] a1, b1v, o1;
    model(s, lat, flt, errw, 1'b0, cnt, a1, b1v, o1);
    @(posedge clk); #1 st[i] = 1'b1;
    @(posedge clk); #1 st[i] = 1'b0;
    n = 0;
    while (n < 5000 && !dn[i]) begin
      @(posedge clk); #1 n++;
      if (i == 3 && (n == 20 || n == 255))
        chk("sat_hold", ec[3], 15);
    end
    chk($sformatf("ext%0d_done_edge", i), n, 256 * (s + 1));
    chk($sformatf("ext%0d_busy", i), bs[i], 0);
    chk($sformatf("ext%0d_err", i), ec[i], cnt);
    chk($sformatf("ext%0d_pass", i), ps[i], cnt == 0);
    chk($sformatf("ext%0d_fail_a", i), fa[i], a1);
    chk($sformatf("ext%0d_fail_b", i), fb[i], b1v);
    chk($sformatf("ext%0d_fail_out", i), fo[i], o1);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst_n = 1'b0; trk = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    st = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", bs[i], 0);
      chk("rst_done", dn[i], 0);
      chk("rst_pass", ps[i], 0);
      chk("rst_err", ec[i], 0);
      chk("rst_a", aa[i], 0);
      chk("rst_b", bb[i], 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    run0(1'b0, 0);
    chk("pass_lit_err", ec[0], 0);
    chk("pass_lit_pass", ps[0], 1);

    run0(1'b0, 1);
    chk("stuck_lit_err", ec[0], 64);
    chk("stuck_lit_pass", ps[0], 0);
    chk("stuck_lit_fa", fa[0], 4'h1);
    chk("stuck_lit_fb", fb[0], 4'h1);
    chk("stuck_lit_fo", fo[0], 4'h0);

    run0(1'b1, 0);
    pulse_rst();

    mode0 = 1;
    begin : midrst
      int cnt;
      logic [3:0] a1, b1v, o1;
      model(0, 0, 1, 32, 1'b1, cnt, a1, b1v, o1);
    end
    hold = 1'b0;
    @(posedge clk); #1 st[0] = 1'b1; k = -1; trk = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0; trk = 1'b0;
    #1;
    chk("mid_a", aa[0], 0);
    chk("mid_b", bb[0], 0);
    chk("mid_busy", bs[0], 0);
    chk("mid_done", dn[0], 0);
    chk("mid_pass", ps[0], 0);
    chk("mid_err", ec[0], 0);
    chk("mid_fa", fa[0], 0);
    chk("mid_fb", fb[0], 0);
    chk("mid_fo", fo[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run0(1'b0, 0);

    pulse_rst();
    fork
      run_ext(1, 2, 2, 0, 32);
      run_ext(2, 1, 2, 0, 32);
      run_ext(3, 0, 0, 2, 4);
    join
    chk("pipe2_lit_pass", ps[1], 1);
    chk("pipe1_lit_pass", ps[2], 0);
    chk("pipe1_lit_errnz", ec[2] != 0, 1);
    chk("sat_lit_err", ec[3], 4'hF);
    chk("sat_lit_fa", fa[3], 4'h0);
    chk("sat_lit_fb", fb[3], 4'h0);
    chk("sat_lit_fo", fo[3], 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/and16_checker.md
# and16_checker

Synthesizable response checker and stimulus sequencer for the 16-bit bitwise AND unit (`And16`). It sits opposite the DUT: it drives every operand pair onto `A`/`B` and samples `OUT`. It then compares `OUT` against the golden `A & B`, counts mismatches and records the first failing vector. It is the in-silicon counterpart to the simulation bench sweep and is used for BIST and FPGA bring-up.

## Interface
- `WIDTH`, 16, operand width; the sweep covers all 2^(2·WIDTH) pairs.
- `SETTLE`, 0, extra cycles each vector is held before sampling; range 0..15.
- `ERR_W`, 32, width of the mismatch counter.
- `CLK` input 1: the single clock.
- `RST_N` input 1: asynchronous, active-low reset.
- `START` input 1: begin a sweep; honoured in IDLE and DONE only.
- `DUT_OUT` input WIDTH: result returned by the DUT.
- `DUT_A` output WIDTH: operand A driven to the DUT; registered.
- `DUT_B` output WIDTH: operand B driven to the DUT; registered.
- `BUSY` output 1: sweep in progress.
- `DONE` output 1: sweep complete; held until the next START or reset.
- `PASS` output 1: valid with DONE; 1 iff ERR_CNT == 0.
- `ERR_CNT` output ERR_W: number of mismatching vectors; saturates at all-ones.
- `FAIL_A`, `FAIL_B`, `FAIL_OUT` output WIDTH each: operands and DUT result of the first mismatch.

## Operation
- **States:** IDLE, WAIT, CHECK, DONE.
- **IDLE:**
  - START=1 loads DUT_A=0, DUT_B=0 and clears ERR_CNT and the FAIL_* registers.
  - Goes to WAIT if SETTLE>0, else to CHECK.
- **WAIT:** a settle counter counts SETTLE cycles, then the block goes to CHECK.
- **CHECK:**
  - DUT_OUT is compared with DUT_A & DUT_B at the closing edge.
  - On a mismatch, ERR_CNT increments (saturating). The FAIL_* registers capture only if ERR_CNT was 0.
  - The operands then advance, then the block goes to WAIT, or to CHECK if SETTLE=0.
- **Sweep order:** B is the inner loop and A the outer loop.
  - DUT_B increments each vector.
  - When DUT_B wraps from all-ones to 0, DUT_A increments.
- **End of sweep:** after checking DUT_A=DUT_B=all-ones, the operands hold their value and the block goes to DONE.
- **DONE:** DONE=1 and PASS is valid. START=1 restarts exactly as from IDLE.
- **START handling:** START is ignored in WAIT and CHECK. It is level-sampled, so holding it high in DONE restarts the sweep continuously.
- **Outputs:** BUSY=1 in WAIT and CHECK. PASS=0 whenever DONE=0.
- **Arithmetic:**
  - Operand counters are WIDTH-bit with modular wrap.
  - The end-of-sweep condition is an explicit all-ones compare, never a carry-out of a wider counter.

## Timing
- **Reset:** RST_N=0 forces, asynchronously, state=IDLE and every output to 0 (DUT_A, DUT_B, BUSY, DONE, PASS, ERR_CNT, FAIL_*).
- **Reset mid-sweep:** the sweep is abandoned with no residual state, and the next START begins again at vector 0.
- **Per-vector timing:**
  - Each vector is held on DUT_A/DUT_B for exactly SETTLE+1 cycles.
  - DUT_OUT is sampled at the last edge of that window.
  - The DUT must therefore have latency ≤ SETTLE.
- **Start to DONE:** the START-sampling edge is edge 0. DONE rises at edge 2^(2·WIDTH)·(SETTLE+1).
- **Start to BUSY:** BUSY rises the cycle after START is sampled and falls with the rise of DONE.
- **ERR_CNT and FAIL_*** update at the CHECK edge and are visible the following cycle.

## Structure
- **Package `and16_pkg`:**
  - state enum `chk_state_t` (IDLE, WAIT, CHECK, DONE);
  - `ERR_W_DEFAULT`;
  - `SETTLE_W` = 4.
- **Sub-module `operand_sweep`:**
  - holds the A/B counter pair;
  - ports are CLK, RST_N, clear, advance, A, B, last.
- **Top-level logic:** FSM, settle counter, comparator, error counter and first-fail capture.

## Test plan
- **Full pass:** WIDTH=4, SETTLE=0, DUT_OUT = DUT_A & DUT_B, START pulse.
  - DONE at edge 256, PASS=1, ERR_CNT=0, FAIL_* = 0.
- **Stuck-at-0 on bit 0:** WIDTH=4, SETTLE=0, DUT_OUT bit 0 forced to 0.
  - ERR_CNT=64, PASS=0.
  - FAIL_A=4'h1, FAIL_B=4'h1, FAIL_OUT=4'h0.
- **Pipelined DUT:** WIDTH=4, DUT output through two registers.
  - SETTLE=2: PASS=1 with DONE at edge 768.
  - SETTLE=1: PASS=0 and ERR_CNT>0.
- **Reset mid-sweep:** RST_N pulsed low at edge 100 of a sweep.
  - All outputs read 0 immediately (asynchronously).
  - A new START gives DUT_A=DUT_B=0 next cycle and a full pass as in the first scenario.
- **START handling:** START held high for the whole sweep.
  - No restart while BUSY.
  - After DONE, a restart clears ERR_CNT from a prior failing run (seeded by the stuck-at fault, then removed) to 0.
- **Saturation:** ERR_W=4, DUT_OUT = ~(A & B), WIDTH=4.
  - ERR_CNT saturates at 4'hF and never wraps.
  - FAIL_A=0, FAIL_B=0, FAIL_OUT=4'hF.
